// File: rtl/bitcounter_pkg.sv
// Shared types and helpers for the multi-mode bit counter.
package bitcounter_pkg;

  typedef enum logic [1:0] {
    MODE_ONES  = 2'd0,
    MODE_ZEROS = 2'd1,
    MODE_TZ    = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Width of an index into n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bitcounter_multi_if.sv
// Request/result bundle between the switch/register side and the bit counter.
// The parity signal exists only when BITCNT_PARITY_EN is defined.
interface bitcounter_multi_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] data_in;
  logic [CNT_W-1:0] result;
  logic             busy;
  logic             done;
`ifdef BITCNT_PARITY_EN
  logic             parity;
`endif

  modport master (
    output start, mode, data_in,
    input  result, busy, done
`ifdef BITCNT_PARITY_EN
    , input parity
`endif
  );

  modport slave (
    input  start, mode, data_in,
    output result, busy, done
`ifdef BITCNT_PARITY_EN
    , output parity
`endif
  );

endinterface

// File: rtl/bitcounter_chunk.sv
// Combinational evaluation of one BPC-bit slice: popcount, any-set, lowest set index
// and, when BITCNT_PARITY_EN is defined, the XOR of the slice.
module bitcounter_chunk
  import bitcounter_pkg::*;
#(
  parameter  int BPC   = 1,
  localparam int PC_W  = $clog2(BPC + 1),
  localparam int IDX_W = idx_w(BPC)
) (
  input  logic [BPC-1:0]   chunk,
  output logic [PC_W-1:0]  popcount,
  output logic             has_one,
  output logic [IDX_W-1:0] low_idx
`ifdef BITCNT_PARITY_EN
  , output logic           chunk_xor
`endif
);

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    popcount = '0;
    low_idx  = '0;
    for (int i = 0; i < BPC; i++) begin
      popcount = popcount + PC_W'(chunk[i]);
    end
    // Scan downward so the lowest set bit is the last one to write the index.
    for (int i = BPC - 1; i >= 0; i--) begin
      if (chunk[i]) low_idx = IDX_W'(i);
    end
  end

  assign has_one = |chunk;

`ifdef BITCNT_PARITY_EN
  assign chunk_xor = ^chunk;
`endif

endmodule

// File: rtl/bitcounter_multi.sv
// Multi-mode bit counter (ones / zeros / trailing zeros), BPC bits per cycle,
// level start/done handshake with enable-pause. Optional parity via BITCNT_PARITY_EN.
module bitcounter_multi
  import bitcounter_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int BPC   = 1,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  bitcounter_multi_if.slave  bus
);

  localparam int RUNS  = WIDTH / BPC;
  localparam int RW    = $clog2(RUNS + 1);
  localparam int PC_W  = $clog2(BPC + 1);
  localparam int IDX_W = idx_w(BPC);

  if (WIDTH < 2 || BPC < 1 || (WIDTH % BPC) != 0) begin : g_param_err
    $error("bitcounter_multi: WIDTH must be >= 2 and divisible by BPC");
  end

  state_t           state, state_next;
  mode_t            mode_q;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] sh_next;
  logic [CNT_W-1:0] result;
  logic [CNT_W-1:0] inc;
  logic [RW-1:0]    remaining;
  logic             last_run;
  logic             ones_like;

  logic [PC_W-1:0]  c_pop;
  logic             c_has_one;
  logic [IDX_W-1:0] c_idx;
`ifdef BITCNT_PARITY_EN
  logic             c_xor;
  logic             parity;
`endif

  bitcounter_chunk #(.BPC(BPC)) u_chunk (
    .chunk    (shreg[BPC-1:0]),
    .popcount (c_pop),
    .has_one  (c_has_one),
    .low_idx  (c_idx)
`ifdef BITCNT_PARITY_EN
    , .chunk_xor (c_xor)
`endif
  );

  assign sh_next   = shreg >> BPC;
  // "<= 1" rather than "-1 == 0" also terminates a run entered with nothing loaded.
  assign last_run  = (remaining <= RW'(1));
  assign ones_like = (mode_q == MODE_ONES) || (mode_q == MODE_RSVD);

  always_comb begin
    inc = '0;
    case (mode_q)
      MODE_ZEROS: inc = CNT_W'(BPC) - CNT_W'(c_pop);
      MODE_TZ:    inc = c_has_one ? CNT_W'(c_idx) : CNT_W'(BPC);
      default:    inc = CNT_W'(c_pop);
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else if (enable) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (bus.start) state_next = S_RUN;
      S_RUN: begin
        if (last_run ||
            (ones_like && sh_next == '0) ||
            (mode_q == MODE_TZ && c_has_one)) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  if (!bus.start) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg     <= '0;
      result    <= '0;
      remaining <= '0;
      mode_q    <= MODE_ONES;
`ifdef BITCNT_PARITY_EN
      parity    <= 1'b0;
`endif
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          // Keep reloading until start rises; the edge that enters RUN leaves the last load intact.
          if (!bus.start) begin
            shreg     <= bus.data_in;
            mode_q    <= mode_t'(bus.mode);
            result    <= '0;
            remaining <= RW'(RUNS);
`ifdef BITCNT_PARITY_EN
            parity    <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          shreg     <= sh_next;
          remaining <= remaining - RW'(1);
          result    <= result + inc;
`ifdef BITCNT_PARITY_EN
          parity    <= parity ^ c_xor;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy   = (state == S_RUN);
    bus.done   = (state == S_DONE);
    bus.result = result;
  end

`ifdef BITCNT_PARITY_EN
  assign bus.parity = parity;
`endif

endmodule

// File: tb/tb_bitcounter_multi.sv
// Directed bench for bitcounter_multi: three configurations (8/1, 8/2, 16/4) share one
// stimulus bus; each step checks the instance it targets. Parity checks need BITCNT_PARITY_EN.
module tb_bitcounter_multi;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] data;

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  logic       busy_s, done_s;
  logic [4:0] result_s;
`ifdef BITCNT_PARITY_EN
  logic       parity_s;
`endif

  always #5 clock = ~clock;

  bitcounter_multi_if #(.WIDTH(8))  if_a ();
  bitcounter_multi_if #(.WIDTH(8))  if_b ();
  bitcounter_multi_if #(.WIDTH(16)) if_c ();

  assign if_a.start = start;  assign if_a.mode = mode;  assign if_a.data_in = data[7:0];
  assign if_b.start = start;  assign if_b.mode = mode;  assign if_b.data_in = data[7:0];
  assign if_c.start = start;  assign if_c.mode = mode;  assign if_c.data_in = data;

  bitcounter_multi #(.WIDTH(8),  .BPC(1)) dut_a (.clock(clock), .reset_n(reset_n), .enable(enable), .bus(if_a.slave));
  bitcounter_multi #(.WIDTH(8),  .BPC(2)) dut_b (.clock(clock), .reset_n(reset_n), .enable(enable), .bus(if_b.slave));
  bitcounter_multi #(.WIDTH(16), .BPC(4)) dut_c (.clock(clock), .reset_n(reset_n), .enable(enable), .bus(if_c.slave));

  always_comb begin
    busy_s   = if_a.busy;
    done_s   = if_a.done;
    result_s = 5'(if_a.result);
`ifdef BITCNT_PARITY_EN
    parity_s = if_a.parity;
`endif
    case (sel)
      1: begin
        busy_s = if_b.busy; done_s = if_b.done; result_s = 5'(if_b.result);
`ifdef BITCNT_PARITY_EN
        parity_s = if_b.parity;
`endif
      end
      2: begin
        busy_s = if_c.busy; done_s = if_c.done; result_s = if_c.result;
`ifdef BITCNT_PARITY_EN
        parity_s = if_c.parity;
`endif
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One full transaction on instance s: load, start, count RUN cycles, hold DONE, release.
  task automatic run(input int s, input logic [1:0] m, input logic [15:0] d,
                     input int exp_cyc, input int exp_res, input logic exp_par,
                     input string tag);
    int n = 0;
    bit seen = 1'b0;
    sel = s;
    @(negedge clock); start = 1'b0; mode = m; data = d;
    @(negedge clock); start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (i == 0) begin
        data = ~d;
        mode = m ^ 2'b01;
      end
      if (done_s) begin
        seen = 1'b1;
        break;
      end
      if (busy_s) n++;
    end
    check({tag, "_done_seen"}, 32'(seen), 1);
    check({tag, "_cycles"}, n, exp_cyc);
    check({tag, "_result"}, 32'(result_s), exp_res);
`ifdef BITCNT_PARITY_EN
    check({tag, "_parity"}, 32'(parity_s), 32'(exp_par));
`else
    if (exp_par === 1'bx) $display("note: %s parity unknown", tag);
`endif
    repeat (2) @(negedge clock);
    check({tag, "_hold_done"}, 32'(done_s), 1);
    check({tag, "_hold_result"}, 32'(result_s), exp_res);
    start = 1'b0;
    @(negedge clock);
    check({tag, "_release_done"}, 32'(done_s), 0);
    check({tag, "_release_busy"}, 32'(busy_s), 0);
  endtask

  initial begin
    int n;
    bit seen;
    reset_n = 1'b0; enable = 1'b1; start = 1'b0; mode = 2'd0; data = '0;
    #2;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset_busy", 32'(busy_s), 0);
      check("reset_done", 32'(done_s), 0);
      check("reset_result", 32'(result_s), 0);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    run(0, 2'd0, 16'h0055, 7, 4, 1'b0, "ones_55");
    run(0, 2'd0, 16'h0000, 1, 0, 1'b0, "ones_zero");
    run(0, 2'd1, 16'h0000, 8, 8, 1'b0, "zeros_zero");
    run(1, 2'd2, 16'h0028, 2, 3, 1'b1, "tz_28");
    run(1, 2'd2, 16'h0000, 4, 8, 1'b0, "tz_zero");
    run(2, 2'd0, 16'hF00F, 4, 8, 1'b0, "ones_f00f");
    run(2, 2'd0, 16'h0007, 1, 3, 1'b1, "ones_0007");
    run(0, 2'd3, 16'h0055, 7, 4, 1'b0, "rsvd_55");

    // Pause: 8'hB6 in ONES runs 8 cycles, result 5; after 2 processed bits result is 1.
    sel = 0;
    @(negedge clock); start = 1'b0; mode = 2'd0; data = 16'h00B6;
    @(negedge clock); start = 1'b1;
    n = 0;
    repeat (3) begin
      @(negedge clock);
      if (busy_s) n++;
    end
    check("pause_pre_cycles", n, 3);
    check("pause_pre_result", 32'(result_s), 1);
    enable = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("pause_busy", 32'(busy_s), 1);
      check("pause_result", 32'(result_s), 1);
      check("pause_done", 32'(done_s), 0);
    end
    enable = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done_s) begin
        seen = 1'b1;
        break;
      end
      if (busy_s) n++;
    end
    check("pause_done_seen", 32'(seen), 1);
    check("pause_cycles", n, 8);
    check("pause_result_final", 32'(result_s), 5);
`ifdef BITCNT_PARITY_EN
    check("pause_parity", 32'(parity_s), 1);
`endif
    start = 1'b0;
    @(negedge clock);
    check("pause_release_done", 32'(done_s), 0);

    // Async reset mid-RUN; dropping start first must not abort the run.
    @(negedge clock); start = 1'b0; mode = 2'd1; data = 16'h0000;
    @(negedge clock); start = 1'b1;
    repeat (3) @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("start_drop_busy", 32'(busy_s), 1);
    check("start_drop_result", 32'(result_s), 3);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy_s), 0);
    check("async_rst_done", 32'(done_s), 0);
    check("async_rst_result", 32'(result_s), 0);
    #1 reset_n = 1'b1;
    run(0, 2'd0, 16'h00E0, 8, 3, 1'b1, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
